and_gate_unit: RTL and testbench
================================

// Module: and_gate_unit
// PURPOSE
//   Bitwise 2-input AND primitive with an optional registered copy and a
//   high-event counter. Leaf cell used wherever glue logic needs a gated
//   signal. The combinational output y is the primary function and must
//   work with no clock running and reset never asserted.
// PARAMETERS
//   WIDTH      1    bit width of a, b, y, y_q
//   CNT_WIDTH  16   width of the high-event counter (AND_GATE_STATS_EN only)
// PORTS
//   clk        in   1          single clock; all registers on rising edge
//   rst        in   1          asynchronous, active-high reset
//   a          in   WIDTH      operand A
//   b          in   WIDTH      operand B
//   y          out  WIDTH      a & b, purely combinational
//   y_q        out  WIDTH      y registered one cycle
//   hi_cnt     out  CNT_WIDTH  count of rising edges of &y (stats build)
//   hi_cnt_sat out  1          hi_cnt has saturated (stats build)
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-high (rst). Reset
//     takes effect immediately on assertion, independent of clk.
//   - y = a & b bitwise, zero latency. y is independent of clk and rst and
//     is never X when a and b are known, including before any clock edge.
//   - Truth table per bit: 00->0, 01->0, 10->0, 11->1.
//   - X/Z on an input bit: y bit = 0 if the other input bit is 0, else X.
//   - y_q: reset value 0; each rising clk edge with rst low, y_q <= a & b.
//     Latency one cycle.
//   - all_hi = &y (all bits high). all_hi_d: internal register, reset 0,
//     samples all_hi each cycle.
//   - Rise event: all_hi == 1 and all_hi_d == 0 in the same cycle.
//   - hi_cnt: reset 0; increments by 1 on each rise event; saturates at
//     2**CNT_WIDTH-1 (never wraps). hi_cnt_sat: reset 0; 1 while hi_cnt is
//     at maximum.
//   - Reset mid-operation clears y_q, all_hi_d, hi_cnt, hi_cnt_sat at once;
//     y keeps following a & b throughout reset.
//   - all_hi held high over several cycles counts as one event.
// CONFIGURATION
//   AND_GATE_STATS_EN defined: all_hi_d, hi_cnt, hi_cnt_sat are implemented
//     as described above.
//   AND_GATE_STATS_EN undefined: hi_cnt ties to 0 and hi_cnt_sat ties to 0;
//     the counter logic is not built. y and y_q are unchanged.
// TESTING
//   1. No clock, rst undriven: apply (a,b) = 00,01,10,11 at 10-time-unit
//      spacing -> y = 0,0,0,1; each value must be stable before the next step.
//   2. WIDTH=4, a=4'b1100, b=4'b1010 -> y=4'b1000 at once, y_q=4'b1000
//      after one clk edge.
//   3. Assert rst with y_q=1 and no clk edge -> y_q=0 immediately; y still
//      equals a & b.
//   4. Stats build: drive a=b=1 for 3 cycles, drop to 0, then 1 again ->
//      hi_cnt=2.
//   5. Stats build, CNT_WIDTH=2: 5 rise events -> hi_cnt=3, hi_cnt_sat=1.
//   6. Stats build off: any stimulus -> hi_cnt=0, hi_cnt_sat=0.

Source files
------------

// File: rtl/and_gate_unit.sv
// Bitwise AND leaf cell with a registered copy and an optional rising-edge counter on &y.
// Define AND_GATE_STATS_EN to build the counter; otherwise hi_cnt and hi_cnt_sat are tied to 0.
module and_gate_unit #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     y_q,
  output logic [CNT_WIDTH-1:0] hi_cnt,
  output logic                 hi_cnt_sat
);

  // y stays outside every clocked or reset path so it works with no clock running.
  assign y = a & b;

  logic [WIDTH-1:0] yreg_d;
  logic [WIDTH-1:0] yreg_q;

  always_comb begin
    yreg_d = a & b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yreg_q <= '0;
    end else begin
      yreg_q <= yreg_d;
    end
  end

  assign y_q = yreg_q;

`ifdef AND_GATE_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic                 all_hi;
  logic                 allhi_d;
  logic                 allhi_q;
  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_comb begin
    all_hi  = &(a & b);
    allhi_d = all_hi;
    rise    = all_hi & ~allhi_q;
    cnt_d   = rise ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      allhi_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      allhi_q <= allhi_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hi_cnt     = cnt_q;
  // Saturation is exactly "counter at all-ones", so no separate flag register is kept.
  assign hi_cnt_sat = &cnt_q;
`else
  assign hi_cnt     = '0;
  assign hi_cnt_sat = 1'b0;
`endif

endmodule

// File: tb/tb_and_gate_unit.sv
// Directed testbench for and_gate_unit: a WIDTH=1 instance and a WIDTH=4/CNT_WIDTH=2 instance,
// checked every cycle against a behavioural model plus hand-computed literal expectations.
module tb_and_gate_unit;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic       a1, b1;
  logic       y1, yq1;
  logic [15:0] cnt1;
  logic       sat1;
  logic [3:0] a4, b4;
  logic [3:0] y4, yq4;
  logic [1:0] cnt4;
  logic       sat4;

  int checks = 0;
  int errors = 0;

`ifdef AND_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  and_gate_unit #(.WIDTH(1), .CNT_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_q(yq1),
    .hi_cnt(cnt1), .hi_cnt_sat(sat1)
  );

  and_gate_unit #(.WIDTH(4), .CNT_WIDTH(2)) u4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .y_q(yq4),
    .hi_cnt(cnt4), .hi_cnt_sat(sat4)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: last sampled AND result, previous "all high" level and an event count.
  logic [3:0] m_yq4;
  logic       m_yq1;
  bit         m_prev1, m_prev4;
  int         m_cnt1, m_cnt4;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_yq1 = 0; m_yq4 = 0; m_prev1 = 0; m_prev4 = 0; m_cnt1 = 0; m_cnt4 = 0;
    end else begin
      m_yq1 = a1 & b1;
      m_yq4 = a4 & b4;
      if ((a1 & b1) == 1'b1 && !m_prev1 && m_cnt1 < 65535) m_cnt1 = m_cnt1 + 1;
      if ((a4 & b4) == 4'hF && !m_prev4 && m_cnt4 < 3) m_cnt4 = m_cnt4 + 1;
      m_prev1 = ((a1 & b1) == 1'b1);
      m_prev4 = ((a4 & b4) == 4'hF);
    end
  end

  always @(negedge clk) begin
    if (clk_en) begin
      chk("y1", y1, a1 & b1);
      chk("y4", y4, a4 & b4);
      chk("y_q1", yq1, m_yq1);
      chk("y_q4", yq4, m_yq4);
      chk("hi_cnt1", cnt1, STATS ? m_cnt1 : 0);
      chk("hi_cnt4", cnt4, STATS ? m_cnt4 : 0);
      chk("sat1", sat1, STATS ? (m_cnt1 == 65535) : 0);
      chk("sat4", sat4, STATS ? (m_cnt4 == 3) : 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] va [6] = '{4'h0, 4'hF, 4'h5, 4'hA, 4'hC, 4'hF};
  logic [3:0] vb [6] = '{4'hF, 4'h0, 4'hF, 4'h6, 4'h3, 4'hE};
  logic [3:0] vy [6] = '{4'h0, 4'h0, 4'h5, 4'h2, 4'h0, 4'hE};
  logic [1:0] ab;
  logic       ey [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    clk = 0; clk_en = 0;
    a4 = 0; b4 = 0;

    // Pure combinational truth table with no clock and reset untouched.
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      a1 = ab[1]; b1 = ab[0];
      #5;
      chk("tt_y", y1, ey[i]);
      #5;
    end
    a1 = 0; b1 = 0;

    rst = 1;
    #3;
    chk("rst_yq1", yq1, 0);
    chk("rst_yq4", yq4, 0);
    chk("rst_cnt4", cnt4, 0);
    chk("rst_sat4", sat4, 0);
    rst = 0;
    #2;
    clk_en = 1;
    cyc();

    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    chk("w4_y", y4, 4'b1000);
    cyc();
    chk("w4_yq", yq4, 4'b1000);

    // High held three cycles, dropped, raised again: two events.
    a1 = 1; b1 = 1;
    repeat (3) cyc();
    a1 = 0; b1 = 0;
    cyc();
    a1 = 1; b1 = 1;
    repeat (2) cyc();
    chk("hold_cnt", cnt1, STATS ? 2 : 0);
    chk("hold_yq", yq1, 1);

    // Asynchronous reset between edges.
    #1;
    rst = 1;
    #1;
    chk("async_yq1", yq1, 0);
    chk("async_y1", y1, 1);
    chk("async_cnt1", cnt1, 0);
    chk("async_yq4", yq4, 0);
    rst = 0;
    cyc();

    for (int k = 0; k < 5; k++) begin
      a4 = 4'hF; b4 = 4'hF;
      cyc();
      if (k == 1) begin
        chk("sat_cnt2", cnt4, STATS ? 2 : 0);
        chk("sat_flag2", sat4, 0);
      end
      a4 = 4'h0; b4 = 4'h0;
      cyc();
    end
    chk("sat_cnt", cnt4, STATS ? 3 : 0);
    chk("sat_flag", sat4, STATS ? 1 : 0);

    for (int k = 0; k < 6; k++) begin
      a4 = va[k]; b4 = vb[k];
      #1;
      chk("vec_y", y4, vy[k]);
      cyc();
      chk("vec_yq", yq4, vy[k]);
    end

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
